// File: rtl/pll_reconfig_ctrl.sv
// pll_reconfig_ctrl: sequences a retune of the system fractional PLL through its
// Avalon-MM reconfig port (mode, N, M, C0, K, start), then qualifies the
// synchronized locked output before reporting done or err.
// Optional build macro PLLRC_SKIP_UNCHANGED_EN: keep shadows of the last
// successfully written N/M/C0/K and skip register writes whose value is unchanged.
module pll_reconfig_ctrl #(
  parameter int LOCK_TIMEOUT = 500000,
  parameter int LOCK_STABLE  = 1024,
  parameter int CNTW         = 20
) (
  input  logic        refclk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [31:0] cfg_n,
  input  logic [31:0] cfg_m,
  input  logic [31:0] cfg_c0,
  input  logic [31:0] cfg_k,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        pll_ok,
  input  logic        pll_locked,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_write,
  output logic [31:0] mgmt_writedata,
  input  logic        mgmt_waitrequest
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_MODE,
    ST_WR_N,
    ST_WR_M,
    ST_WR_C0,
    ST_WR_K,
    ST_WR_START,
    ST_WAIT_LOCK
  } state_t;

  state_t state, state_nxt;

  logic            lk_meta, lk_s;
  logic [CNTW-1:0] stab_cnt;
  logic [CNTW-1:0] tmo_cnt;
  logic [31:0]     reg_n, reg_m, reg_c0, reg_k;

  logic        wr_done, start_done, accept, succ, fail, tmo_hit;
  logic        is_wr_state, issue, skip_cur, skip_now;
  logic [5:0]  wr_addr_cur;
  logic [31:0] wr_data_cur;
  logic        mgmt_write_nxt, busy_nxt, done_nxt, err_nxt;
  logic [5:0]  mgmt_address_nxt;
  logic [31:0] mgmt_writedata_nxt;

  assign wr_done    = mgmt_write && !mgmt_waitrequest;
  assign start_done = (state == ST_WR_START) && wr_done;
  assign accept     = (state == ST_IDLE) && req;
  assign tmo_hit    = (tmo_cnt == CNTW'(LOCK_TIMEOUT - 1));
  assign succ       = (state == ST_WAIT_LOCK) && pll_ok;
  assign fail       = (state == ST_WAIT_LOCK) && !pll_ok && tmo_hit;
  assign skip_now   = skip_cur && !mgmt_write;

`ifdef PLLRC_SKIP_UNCHANGED_EN
  logic [31:0] sh_n, sh_m, sh_c0, sh_k;
  logic        sh_vld;

  // Decide whether the current counter register matches what the PLL already holds
  always_comb begin
    skip_cur = 1'b0;
    case (state)
      ST_WR_N:  skip_cur = sh_vld && (reg_n  == sh_n);
      ST_WR_M:  skip_cur = sh_vld && (reg_m  == sh_m);
      ST_WR_C0: skip_cur = sh_vld && (reg_c0 == sh_c0);
      ST_WR_K:  skip_cur = sh_vld && (reg_k  == sh_k);
      default:  skip_cur = 1'b0;
    endcase
  end

  // Shadows track the last configuration that reached qualified lock
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      sh_vld <= 1'b0;
      sh_n   <= '0;
      sh_m   <= '0;
      sh_c0  <= '0;
      sh_k   <= '0;
    end else if (fail) begin
      sh_vld <= 1'b0;
    end else if (succ) begin
      sh_vld <= 1'b1;
      sh_n   <= reg_n;
      sh_m   <= reg_m;
      sh_c0  <= reg_c0;
      sh_k   <= reg_k;
    end
  end
`else
  assign skip_cur = 1'b0;
`endif

  // Two-flop synchronizer for the asynchronous PLL locked output
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      lk_meta <= 1'b0;
      lk_s    <= 1'b0;
    end else begin
      lk_meta <= pll_locked;
      lk_s    <= lk_meta;
    end
  end

  // Stability counter and registered lock qualification; restarted when the PLL is kicked
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      stab_cnt <= '0;
      pll_ok   <= 1'b0;
    end else if (start_done) begin
      stab_cnt <= '0;
      pll_ok   <= 1'b0;
    end else begin
      pll_ok <= (stab_cnt == CNTW'(LOCK_STABLE));
      if (!lk_s)
        stab_cnt <= '0;
      else if (stab_cnt != CNTW'(LOCK_STABLE))
        stab_cnt <= stab_cnt + 1'b1;
    end
  end

  // Lock timeout counter, only running while waiting for lock
  always_ff @(posedge refclk) begin
    if (!rst_n)
      tmo_cnt <= '0;
    else if (start_done)
      tmo_cnt <= '0;
    else if (state == ST_WAIT_LOCK)
      tmo_cnt <= tmo_cnt + 1'b1;
  end

  // Capture the requested configuration when a request is accepted
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      reg_n  <= '0;
      reg_m  <= '0;
      reg_c0 <= '0;
      reg_k  <= '0;
    end else if (accept) begin
      reg_n  <= cfg_n;
      reg_m  <= cfg_m;
      reg_c0 <= cfg_c0;
      reg_k  <= cfg_k;
    end
  end

  // State register
  always_ff @(posedge refclk) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic: each write state advances on completion or on a skip
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (accept)              state_nxt = ST_WR_MODE;
      ST_WR_MODE:   if (wr_done)             state_nxt = ST_WR_N;
      ST_WR_N:      if (wr_done || skip_now) state_nxt = ST_WR_M;
      ST_WR_M:      if (wr_done || skip_now) state_nxt = ST_WR_C0;
      ST_WR_C0:     if (wr_done || skip_now) state_nxt = ST_WR_K;
      ST_WR_K:      if (wr_done || skip_now) state_nxt = ST_WR_START;
      ST_WR_START:  if (wr_done)             state_nxt = ST_WAIT_LOCK;
      ST_WAIT_LOCK: if (succ || fail)        state_nxt = ST_IDLE;
      default:                               state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: register address/data per state and the next values of the status flags
  always_comb begin
    is_wr_state = 1'b1;
    wr_addr_cur = 6'd0;
    wr_data_cur = 32'd0;
    case (state)
      ST_WR_MODE:  begin wr_addr_cur = 6'd0; wr_data_cur = 32'd0;  end
      ST_WR_N:     begin wr_addr_cur = 6'd3; wr_data_cur = reg_n;  end
      ST_WR_M:     begin wr_addr_cur = 6'd4; wr_data_cur = reg_m;  end
      ST_WR_C0:    begin wr_addr_cur = 6'd5; wr_data_cur = reg_c0; end
      ST_WR_K:     begin wr_addr_cur = 6'd7; wr_data_cur = reg_k;  end
      ST_WR_START: begin wr_addr_cur = 6'd2; wr_data_cur = 32'd0;  end
      default:     is_wr_state = 1'b0;
    endcase

    issue = is_wr_state && !mgmt_write && !skip_cur;

    mgmt_write_nxt     = mgmt_write;
    mgmt_address_nxt   = mgmt_address;
    mgmt_writedata_nxt = mgmt_writedata;
    if (issue) begin
      mgmt_write_nxt     = 1'b1;
      mgmt_address_nxt   = wr_addr_cur;
      mgmt_writedata_nxt = wr_data_cur;
    end else if (wr_done) begin
      mgmt_write_nxt = 1'b0;
    end

    busy_nxt = busy;
    err_nxt  = err;
    done_nxt = succ;
    if (accept) begin
      busy_nxt = 1'b1;
      err_nxt  = 1'b0;
    end else if (succ) begin
      busy_nxt = 1'b0;
    end else if (fail) begin
      busy_nxt = 1'b0;
      err_nxt  = 1'b1;
    end
  end

  // Output registers; reset drops any in-flight write immediately
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      mgmt_write     <= 1'b0;
      mgmt_address   <= '0;
      mgmt_writedata <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
    end else begin
      mgmt_write     <= mgmt_write_nxt;
      mgmt_address   <= mgmt_address_nxt;
      mgmt_writedata <= mgmt_writedata_nxt;
      busy           <= busy_nxt;
      done           <= done_nxt;
      err            <= err_nxt;
    end
  end

endmodule

// File: doc/pll_reconfig_ctrl.md
Name: pll_reconfig_ctrl

Overview:
Sequencer for the Avalon-MM reconfiguration port of the system fractional PLL (50 MHz reference, 42.666 MHz core clock by default). Accepts one retune request at a time carrying N, M, C0 and K values. Writes the PLL reconfig registers in a fixed order, triggers the reconfiguration, then qualifies the PLL's locked output before reporting done or error. Runs in the reference clock domain, between the frontend/OSD retune logic and the PLL reconfig core.

Parameters:
LOCK_TIMEOUT, 500000, cycles allowed from start-write completion to qualified lock (10 ms at 50 MHz); minimum 2.
LOCK_STABLE, 1024, consecutive cycles synchronized locked must stay high to qualify lock; minimum 1.
CNTW, 20, width of the internal timeout and stability counters; must hold LOCK_TIMEOUT.

Ports:
refclk  in  1  sole clock, 50 MHz reference.
rst_n  in  1  reset; synchronous to refclk, active-low.
req  in  1  retune request, level; sampled only in IDLE.
cfg_n  in  32  N counter register value.
cfg_m  in  32  M counter register value.
cfg_c0  in  32  C0 counter register value, counter-select bits [22:18] already 0.
cfg_k  in  32  fractional K value.
busy  out  1  high from request acceptance until done/err.
done  out  1  one-cycle pulse on successful retune.
err  out  1  lock timeout flag; held until next accepted request.
pll_ok  out  1  level, high while qualified lock holds (any state).
pll_locked  in  1  PLL locked output; asynchronous.
mgmt_address  out  6  reconfig register address.
mgmt_write  out  1  write strobe.
mgmt_writedata  out  32  write data.
mgmt_waitrequest  in  1  reconfig core stall.

Behaviour:
- Reset (rst_n low at a refclk edge): state IDLE. busy, done, err, pll_ok, mgmt_write = 0; mgmt_address = 0; mgmt_writedata = 0; all counters 0; sync flops 0. Reset during a write drops mgmt_write on that edge; there is no completion of a partial sequence.
- pll_locked passes through a 2-flop synchronizer (lk_s). A stability counter increments while lk_s = 1 and saturates at LOCK_STABLE. It clears on any cycle with lk_s = 0. pll_ok = (counter == LOCK_STABLE), registered.
- IDLE: if req = 1, register cfg_* and set busy = 1. Clear err, then go to WR_MODE. Requests outside IDLE are ignored; there is no queueing.
- Write states in order: WR_MODE (addr 0, data 0 = waitrequest mode), WR_N (addr 3), WR_M (addr 4), WR_C0 (addr 5), WR_K (addr 7), WR_START (addr 2, data 0).
- Write handshake: on state entry, drive mgmt_write = 1 with address and data registered. Hold all three stable while mgmt_waitrequest = 1. The write completes at the first edge with mgmt_write = 1 and mgmt_waitrequest = 0. On that edge, advance and drop mgmt_write for exactly one cycle before the next write. Minimum 2 cycles per register.
- Completion of WR_START clears the stability counter, loads the timeout counter with 0 and enters WAIT_LOCK.
- WAIT_LOCK: the timeout counter increments each cycle.
  - If pll_ok = 1 first: pulse done for 1 cycle, busy = 0, go to IDLE.
  - Otherwise, when the timeout counter reaches LOCK_TIMEOUT: err = 1, busy = 0, go to IDLE.
  - If the stability count reaches LOCK_STABLE on the same cycle the timeout is hit, success wins.
- done and err are never high together. busy falls on the same edge done rises or err is set.
- There is no limit on waitrequest stalls during the write states; the lock timeout only applies in WAIT_LOCK.

Optional Feature:
PLLRC_SKIP_UNCHANGED_EN: when defined, the block keeps a shadow copy of the last successfully written N/M/C0/K plus a valid bit.
- The valid bit is 0 at reset and on err.
- Each of WR_N..WR_K is skipped, taking one cycle with no write, when valid = 1 and the value equals its shadow.
- WR_MODE and WR_START are always issued.
- The shadows update when done pulses.
When undefined, all six writes are always issued and no shadow registers exist.

Test Plan:
1. Reset, then req with N=0x00000202, M=0x00000808, C0=0x00000303, K=0x8F5C28F6, waitrequest tied 0. Expect writes to addr 0,3,4,5,7,2 with those data, each mgmt_write one cycle wide and separated by one idle cycle. After the start write, hold pll_locked high: done pulses exactly LOCK_STABLE+2 cycles later.
2. Waitrequest held high for 5 cycles on WR_M. Expect address/data stable for 6 cycles of mgmt_write, then the sequence continues; final done.
3. pll_locked never rises. Expect err = 1 after LOCK_TIMEOUT cycles in WAIT_LOCK, busy = 0, done never pulses. The next req clears err.
4. pll_locked glitches low for 1 cycle at count LOCK_STABLE−5. Expect the stability counter restarts and done is delayed by the full LOCK_STABLE.
5. rst_n low for 1 cycle mid-WR_C0 with waitrequest high. Expect mgmt_write = 0 and busy = 0 the next cycle. The next req restarts at WR_MODE.
6. With PLLRC_SKIP_UNCHANGED_EN, issue two identical successful requests. The second issues only addr 0 and addr 2 writes. Change K only: expect writes to 0, 7, 2.
